fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 115 +++++++++++
 tb/tb_fetch_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order FIFO of {instruction, pc} pairs between fetch and decode.
// The optional same-cycle bypass from input to head is enabled by defining
// the macro FETCH_BUF_BYPASS_EN. When the macro is undefined, every instruction
// reaches the head one cycle after it is written.
// The control state (count and pointers) is reset. The storage entries are not reset.
`ifndef XLEN
`define XLEN 32
`endif

module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [`XLEN-1:0]        in_inst,
  input  logic [`XLEN-1:0]        in_pc,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [`XLEN-1:0]        out_inst,
  output logic [`XLEN-1:0]        out_pc,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [`XLEN-1:0] inst_mem_q [DEPTH];
  logic [`XLEN-1:0] pc_mem_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic head_valid;
  logic bypass;
  logic push, pop;
  logic wr_en, rd_en;

  assign head_valid = (count_q != '0);

`ifdef FETCH_BUF_BYPASS_EN
  // An empty buffer passes the input directly to decode when decode can take it.
  assign bypass = !head_valid && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Handshake and head presentation. Outputs are zero whenever nothing is valid.
  always_comb begin
    in_ready  = (count_q < FULL_C) && !flush;
    out_valid = (head_valid && !flush) || bypass;
    out_inst  = '0;
    out_pc    = '0;
    if (head_valid && !flush) begin
      out_inst = inst_mem_q[rd_ptr_q];
      out_pc   = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_inst = in_inst;
      out_pc   = in_pc;
    end
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready;
    // A bypassed instruction is consumed in flight. It touches neither the storage nor the pointers.
    wr_en = push && !bypass;
    rd_en = pop && !bypass;
  end

  // Next pointer and occupancy. Flush clears everything and drops this cycle's input.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers. Reset takes priority over flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. It is written only at a free slot, because wr_en implies the buffer is not full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem_q[wr_ptr_q] <= in_inst;
      pc_mem_q[wr_ptr_q]   <= in_pc;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with a scoreboard queue for fetch_buffer (DEPTH=2).
`ifndef XLEN
`define XLEN 32
`endif

module tb_fetch_buffer;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [`XLEN-1:0]  in_inst;
  logic [`XLEN-1:0]  in_pc;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [`XLEN-1:0]  out_inst;
  logic [`XLEN-1:0]  out_pc;
  logic              out_ready;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_err = 0;
  entry_t exp_q[$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes one expected entry whenever the head is accepted by decode.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output_pc", {32'b0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", {32'b0, out_pc}, {32'b0, e.pc});
            chk("out_inst", {32'b0, out_inst}, {32'b0, e.inst});
          end
        end else if (out_valid === 1'b0) begin
          chk("idle_out_zero", {out_inst, out_pc}, 64'h0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset: two cycles
    tick; tick;
    rst = 1'b0;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_inst", {32'b0, out_inst}, 64'd0);
    chk("rst_out_pc", {32'b0, out_pc}, 64'd0);
    chk("rst_count", {62'b0, count}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Fill to full with decode stalled
    drive(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
    exp_q.push_back('{inst: 32'h0000_0013, pc: 32'h0});
    tick;
    chk("fill1_count", {62'b0, count}, 64'd1);
    drive(1'b1, 32'h0010_0093, 32'h4, 1'b0, 1'b0);
    exp_q.push_back('{inst: 32'h0010_0093, pc: 32'h4});
    tick;
    chk("full_count", {62'b0, count}, 64'd2);
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    chk("full_out_valid", {63'b0, out_valid}, 64'd1);
    chk("full_head_pc", {32'b0, out_pc}, 64'h0);
    chk("full_head_inst", {32'b0, out_inst}, 64'h13);
    drive(1'b1, 32'h0020_0113, 32'h8, 1'b0, 1'b0);
    #1 chk("refuse_in_ready", {63'b0, in_ready}, 64'd0);
    tick;
    chk("refuse_count", {62'b0, count}, 64'd2);
    chk("stall_head_pc", {32'b0, out_pc}, 64'h0);
    chk("stall_head_inst", {32'b0, out_inst}, 64'h13);

    // Drain in order
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick;
    chk("drain1_count", {62'b0, count}, 64'd1);
    tick;
    chk("drain_count", {62'b0, count}, 64'd0);
    chk("drain_out_valid", {63'b0, out_valid}, 64'd0);

    // Continuous stream with wrap
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + i, 32'(i * 4), 1'b1, 1'b0);
      exp_q.push_back('{inst: 32'h1000 + i, pc: 32'(i * 4)});
      tick;
`ifdef FETCH_BUF_BYPASS_EN
      chk("stream_count", {62'b0, count}, 64'd0);
`else
      chk("stream_count", {62'b0, count}, 64'd1);
`endif
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick;
    chk("stream_end_count", {62'b0, count}, 64'd0);

    // Flush with two entries held and a concurrent input
    drive(1'b1, 32'hAAAA_0001, 32'h20, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'hAAAA_0002, 32'h24, 1'b0, 1'b0);
    tick;
    chk("preflush_count", {62'b0, count}, 64'd2);
    drive(1'b1, 32'hBBBB_0040, 32'h40, 1'b0, 1'b1);
    #1;
    chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    tick;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("postflush_count", {62'b0, count}, 64'd0);
    chk("postflush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("postflush_out_pc", {32'b0, out_pc}, 64'd0);
    tick; tick;

    // Bypass and latency check from empty
    drive(1'b1, 32'h0000_0200, 32'h100, 1'b1, 1'b0);
    exp_q.push_back('{inst: 32'h0000_0200, pc: 32'h100});
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    chk("byp_out_valid", {63'b0, out_valid}, 64'd1);
    chk("byp_out_pc", {32'b0, out_pc}, 64'h100);
    tick;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("byp_count", {62'b0, count}, 64'd0);
`else
    chk("nobyp_out_valid", {63'b0, out_valid}, 64'd0);
    tick;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("nobyp_count", {62'b0, count}, 64'd1);
    chk("nobyp_out_pc", {32'b0, out_pc}, 64'h100);
    tick;
    chk("nobyp_count_after", {62'b0, count}, 64'd0);
`endif

    // Reset in the middle of a stream discards the held entries
    drive(1'b1, 32'hCCCC_0001, 32'h80, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'hCCCC_0002, 32'h84, 1'b0, 1'b0);
    tick;
    chk("prerst_count", {62'b0, count}, 64'd2);
    drive(1'b1, 32'hCCCC_0003, 32'h88, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("midrst_count", {62'b0, count}, 64'd0);
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    tick; tick;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
